// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx between NUM_REQ byte producers, with watchdog abort.
// Latency: req to newd is 1 clk; ack pulses 1 clk after the donetx rising edge is seen.
// Backpressure: requesters hold req until their ack; newd is held until donetx rises or the watchdog fires.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 2048
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       newd,
   output logic [7:0]                 tx_data,
   input  logic                       donetx,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       timeout_err
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state;
   logic [GW-1:0]   rr_ptr;
   logic [WW-1:0]   wdog;
   logic            donetx_q;
   logic            done_rise;
   logic            found;
   logic [GW-1:0]   sel_idx;
   logic [GW-1:0]   next_ptr;
   int              cand;

   assign done_rise = donetx & ~donetx_q;

   // The pointer moves past whoever was last served, whether the byte completed or timed out.
   assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   // Pick the first active request scanning upward from rr_ptr with wrap-around.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      cand    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req[cand]) begin
            found   = 1'b1;
            sel_idx = GW'(cand);
         end
      end
   end

   // One-flop history of donetx so a completion is taken from its rising edge only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) donetx_q <= 1'b0;
      else      donetx_q <= donetx;
   end

   // Arbitration FSM: grant in IDLE, hold newd in SEND, wait out a stale donetx level in GAP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         newd        <= 1'b0;
         busy        <= 1'b0;
         ack         <= '0;
         timeout_err <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         rr_ptr      <= '0;
         wdog        <= '0;
      end else begin
         ack         <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= sel_idx;
                  tx_data  <= req_data[sel_idx*8 +: 8];
                  wdog     <= '0;
                  newd     <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               // A completion seen on the last watchdog cycle still counts as a completion.
               if (done_rise) begin
                  newd          <= 1'b0;
                  ack           <= NUM_REQ'(1) << grant_id;
                  rr_ptr        <= next_ptr;
                  state         <= GAP;
               end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
                  newd          <= 1'b0;
                  timeout_err   <= 1'b1;
                  rr_ptr        <= next_ptr;
                  state         <= GAP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            GAP: begin
               if (!donetx) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
